// File: rtl/aclk_key_entry.sv
// Keypad digit-entry buffer for the alarm clock: collects HH:MM digits, validates them
// as a 24-hour time and issues a one-cycle load pulse to the time counter or alarm register.
module aclk_key_entry #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_one_second,
    input  logic       i_key_valid,
    input  logic [3:0] i_key,
    output logic       o_key_ready,
    output logic [3:0] o_new_time_ms_hr,
    output logic [3:0] o_new_time_ls_hr,
    output logic [3:0] o_new_time_ms_min,
    output logic [3:0] o_new_time_ls_min,
    output logic       o_load_new_c,
    output logic       o_load_new_a,
    output logic       o_entry_error,
    output logic       o_entry_timeout
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned TW = 8;

    localparam logic [DW-1:0] K_MAX_DIGIT = DW'(9);
    localparam logic [DW-1:0] K_SET_TIME  = DW'(10);
    localparam logic [DW-1:0] K_SET_ALARM = DW'(11);
    localparam logic [DW-1:0] K_CLEAR     = DW'(12);
    localparam logic [CW-1:0] CNT_FULL    = CW'(4);
    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_LOAD_C = 3'd2,
        S_LOAD_A = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    logic [DW-1:0]  w_ms_hr_nxt, w_ls_hr_nxt, w_ms_min_nxt, w_ls_min_nxt;
    logic [CW-1:0]  r_count, w_count_nxt;
    logic [TW-1:0]  r_timer, w_timer_nxt;
    logic [TW-1:0]  w_timer_inc;
    logic           w_timeout;
    logic           w_key_acc;
    logic           w_time_ok;

    logic r_key_ready, r_load_c, r_load_a, r_error, r_timeout;
    logic w_key_ready_nxt, w_load_c_nxt, w_load_a_nxt, w_error_nxt, w_timeout_nxt;

    assign w_key_acc   = i_key_valid && ((r_state == S_IDLE) || (r_state == S_ENTRY));
    assign w_timer_inc = (r_timer == TIMER_MAX) ? r_timer : r_timer + TW'(1);

    // Buffer must be complete and form a legal 24-hour HH:MM
    assign w_time_ok = (r_count == CNT_FULL)
                    && (r_ms_hr <= DW'(2))
                    && ((r_ms_hr == DW'(2)) ? (r_ls_hr <= DW'(3)) : (r_ls_hr <= DW'(9)))
                    && (r_ms_min <= DW'(5))
                    && (r_ls_min <= DW'(9));

    // State and datapath register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ms_hr     <= '0;
            r_ls_hr     <= '0;
            r_ms_min    <= '0;
            r_ls_min    <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_key_ready <= 1'b1;
            r_load_c    <= 1'b0;
            r_load_a    <= 1'b0;
            r_error     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ms_hr     <= w_ms_hr_nxt;
            r_ls_hr     <= w_ls_hr_nxt;
            r_ms_min    <= w_ms_min_nxt;
            r_ls_min    <= w_ls_min_nxt;
            r_count     <= w_count_nxt;
            r_timer     <= w_timer_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_load_c    <= w_load_c_nxt;
            r_load_a    <= w_load_a_nxt;
            r_error     <= w_error_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state and buffer update
    always_comb begin
        w_state_nxt  = r_state;
        w_ms_hr_nxt  = r_ms_hr;
        w_ls_hr_nxt  = r_ls_hr;
        w_ms_min_nxt = r_ms_min;
        w_ls_min_nxt = r_ls_min;
        w_count_nxt  = r_count;
        w_timer_nxt  = r_timer;
        w_timeout    = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (w_key_acc && (i_key <= K_MAX_DIGIT)) begin
                    w_timer_nxt = '0;
                    if (r_count < CNT_FULL) begin
                        w_ms_hr_nxt  = r_ls_hr;
                        w_ls_hr_nxt  = r_ms_min;
                        w_ms_min_nxt = r_ls_min;
                        w_ls_min_nxt = i_key;
                        w_count_nxt  = r_count + CW'(1);
                        w_state_nxt  = S_ENTRY;
                    end
                end else if (w_key_acc && (i_key == K_CLEAR)) begin
                    w_ms_hr_nxt  = '0;
                    w_ls_hr_nxt  = '0;
                    w_ms_min_nxt = '0;
                    w_ls_min_nxt = '0;
                    w_count_nxt  = '0;
                    w_timer_nxt  = '0;
                    w_state_nxt  = S_IDLE;
                end else if (w_key_acc && ((i_key == K_SET_TIME) || (i_key == K_SET_ALARM))) begin
                    w_timer_nxt = '0;
                    if (!w_time_ok) begin
                        w_state_nxt = S_REJECT;
                    end else if (i_key == K_SET_TIME) begin
                        w_state_nxt = S_LOAD_C;
                    end else begin
                        w_state_nxt = S_LOAD_A;
                    end
                end else if ((r_state == S_ENTRY) && i_one_second) begin
                    // Unused keys 13-15 fall through here and do not disturb the timer
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc >= TIMER_LIMIT) begin
                        w_timeout    = 1'b1;
                        w_ms_hr_nxt  = '0;
                        w_ls_hr_nxt  = '0;
                        w_ms_min_nxt = '0;
                        w_ls_min_nxt = '0;
                        w_count_nxt  = '0;
                        w_timer_nxt  = '0;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            S_LOAD_C, S_LOAD_A, S_REJECT: begin
                w_ms_hr_nxt  = '0;
                w_ls_hr_nxt  = '0;
                w_ms_min_nxt = '0;
                w_ls_min_nxt = '0;
                w_count_nxt  = '0;
                w_timer_nxt  = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered
    always_comb begin
        w_key_ready_nxt = 1'b0;
        w_load_c_nxt    = 1'b0;
        w_load_a_nxt    = 1'b0;
        w_error_nxt     = 1'b0;
        w_timeout_nxt   = w_timeout;
        case (w_state_nxt)
            S_IDLE, S_ENTRY: w_key_ready_nxt = 1'b1;
            S_LOAD_C:        w_load_c_nxt    = 1'b1;
            S_LOAD_A:        w_load_a_nxt    = 1'b1;
            S_REJECT:        w_error_nxt     = 1'b1;
            default:         w_key_ready_nxt = 1'b0;
        endcase
    end

    assign o_key_ready       = r_key_ready;
    assign o_new_time_ms_hr  = r_ms_hr;
    assign o_new_time_ls_hr  = r_ls_hr;
    assign o_new_time_ms_min = r_ms_min;
    assign o_new_time_ls_min = r_ls_min;
    assign o_load_new_c      = r_load_c;
    assign o_load_new_a      = r_load_a;
    assign o_entry_error     = r_error;
    assign o_entry_timeout   = r_timeout;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Bench for aclk_key_entry: directed scenarios plus randomized key/tick traffic scored
// against a queue-based reference model of the entry buffer.
module tb_aclk_key_entry;

    localparam int unsigned TO = 10;
    localparam logic [2:0] EV_C   = 3'd1;
    localparam logic [2:0] EV_A   = 3'd2;
    localparam logic [2:0] EV_ERR = 3'd3;
    localparam logic [2:0] EV_TMO = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       key_ready;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_c, load_a, err, tmo;

    aclk_key_entry #(.TIMEOUT_SEC(TO)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_one_second     (one_second),
        .i_key_valid      (key_valid),
        .i_key            (key),
        .o_key_ready      (key_ready),
        .o_new_time_ms_hr (ms_hr),
        .o_new_time_ls_hr (ls_hr),
        .o_new_time_ms_min(ms_min),
        .o_new_time_ls_min(ls_min),
        .o_load_new_c     (load_c),
        .o_load_new_a     (load_a),
        .o_entry_error    (err),
        .o_entry_timeout  (tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] dig;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;

    // Reference model: entered digits (oldest first), seconds idle, busy = load/reject cycle
    int  m_q[$];
    int  m_timer = 0;
    bit  m_busy = 1'b0;
    bit  m_entry = 1'b0;

    function automatic logic [15:0] m_digits();
        logic [15:0] v = 16'h0;
        foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
        return v;
    endfunction

    function automatic bit m_time_ok();
        if (m_q.size() != 4) return 1'b0;
        return ((m_q[0] * 10 + m_q[1]) < 24) && ((m_q[2] * 10 + m_q[3]) < 60);
    endfunction

    task automatic push_ev(input logic [2:0] kind);
        ev_t e;
        e.kind = kind;
        e.dig  = m_digits();
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit rst, input bit kv, input logic [3:0] k, input bit tick);
        if (rst) begin
            m_q.delete(); m_timer = 0; m_busy = 1'b0; m_entry = 1'b0;
            return;
        end
        if (m_busy) begin
            m_q.delete(); m_busy = 1'b0;
            return;
        end
        if (kv && k <= 4'd9) begin
            if (m_q.size() < 4) m_q.push_back(int'(k));
            m_timer = 0; m_entry = 1'b1;
        end else if (kv && k == 4'd12) begin
            m_q.delete(); m_timer = 0; m_entry = 1'b0;
        end else if (kv && (k == 4'd10 || k == 4'd11)) begin
            if (!m_time_ok()) push_ev(EV_ERR);
            else if (k == 4'd10) push_ev(EV_C);
            else push_ev(EV_A);
            m_busy = 1'b1; m_timer = 0; m_entry = 1'b0;
        end else if (m_entry && tick) begin
            if (m_timer < 255) m_timer++;
            if (m_timer >= int'(TO)) begin
                push_ev(EV_TMO);
                m_q.delete(); m_timer = 0; m_entry = 1'b0;
            end
        end
    endtask

    task automatic step(input bit kv, input logic [3:0] k, input bit tick, input bit rst);
        @(negedge clk);
        key_valid = kv; key = k; one_second = tick; reset = rst;
        model_step(rst, kv, k, tick);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every pulse, and checks handshake/buffer each cycle
    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            automatic int npulse = int'(load_c) + int'(load_a) + int'(err) + int'(tmo);
            automatic logic [15:0] act_dig = {ms_hr, ls_hr, ms_min, ls_min};
            automatic logic [2:0] act_kind = load_c ? EV_C : load_a ? EV_A : err ? EV_ERR : EV_TMO;
            ev_t e;
            total++;
            if (npulse > 1) begin
                bad++;
                $display("FAIL onehot: got %0d pulses want at most 1 at %0t", npulse, $time);
            end
            if (npulse >= 1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_pulse: got kind %0d want none at %0t", act_kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act_kind != e.kind) begin
                        bad++;
                        $display("FAIL pulse_kind: got %0d want %0d at %0t", act_kind, e.kind, $time);
                    end
                    if (e.kind == EV_C || e.kind == EV_A) begin
                        total++;
                        if (act_dig != e.dig) begin
                            bad++;
                            $display("FAIL load_digits: got %h want %h at %0t", act_dig, e.dig, $time);
                        end
                    end
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_pulse: got none want kind %0d at %0t", e.kind, $time);
            end
            total++;
            if (key_ready != !m_busy) begin
                bad++;
                $display("FAIL key_ready: got %0b want %0b at %0t", key_ready, !m_busy, $time);
            end
            total++;
            if (act_dig != m_digits()) begin
                bad++;
                $display("FAIL buffer: got %h want %h at %0t", act_dig, m_digits(), $time);
            end
        end
    end

    initial begin
        @(posedge clk);
        mon_en = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        idle(2);

        // Valid time load, invalid hours, invalid minutes
        press(2); press(3); press(5); press(9); press(10); idle(2);
        press(2); press(4); press(0); press(0); press(11); idle(2);
        press(0); press(9); press(6); press(0); press(11); idle(2);
        press(1); press(9); press(5); press(9); press(11); idle(2);
        // Incomplete entry, fifth digit ignored, SET from IDLE
        press(1); press(2); press(10); idle(2);
        press(1); press(2); press(3); press(4); press(5); idle(1); press(12); idle(1);
        press(10); idle(2);
        // Timeout, and a digit on the final tick cancelling it
        press(7); ticks(TO); idle(2);
        press(7); ticks(TO - 1); step(1'b1, 4'd3, 1'b1, 1'b0); ticks(TO - 1); idle(1);
        press(14); ticks(1); idle(2);
        // Key dropped during LOAD_C, CLEAR mid-entry
        press(2); press(3); press(5); press(9); press(10); press(4); idle(1);
        press(1); press(12); idle(2);
        // Reset in LOAD_C and mid-entry
        press(2); press(3); press(5); press(9); press(10); step(1'b0, 4'd0, 1'b0, 1'b1); idle(2);
        press(1); press(2); step(1'b0, 4'd0, 1'b1, 1'b1); idle(2);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    logic [3:0] d [4];
                    d[0] = 4'($urandom_range(0, 2)); d[1] = 4'($urandom_range(0, 9));
                    d[2] = 4'($urandom_range(0, 6)); d[3] = 4'($urandom_range(0, 9));
                    for (int j = 0; j < 4; j++) begin
                        step(1'b1, d[j], $urandom_range(0, 3) == 0, 1'b0);
                        if ($urandom_range(0, 3) == 0) idle(1);
                    end
                    press(4'($urandom_range(10, 11)));
                    idle(int'($urandom_range(0, 2)));
                end
                1: begin
                    for (int j = 0; j < 20; j++)
                        step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
                end
                2: begin
                    press(4'($urandom_range(0, 9)));
                    for (int j = 0; j < int'(TO) + 2; j++)
                        step($urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 4) != 0, 1'b0);
                end
                default: begin
                    for (int j = 0; j < 6; j++)
                        step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 12)), 1'b0, 1'b0);
                end
            endcase
        end
        idle(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
